up_counter_ctrl: RTL

Sequencing controller for the team's WIDTH-bit synchronous up counter. It drives the counter's clear and enable from start/pause/abort controls and compares the returned count against a latched limit. It supports a one-shot mode and an auto-reload mode, and reports busy, a done pulse and a completed-period count. It sits between control logic and the counter instance; the counter remains a separate module.

---
 rtl/up_counter_ctrl.sv | 100 ++++++++++
 1 files changed

// File: rtl/up_counter_ctrl.sv
`timescale 1ns/1ps
// Sequencing controller for an external WIDTH-bit up counter: drives clear/enable,
// compares the returned count against a latched limit, one-shot or auto-reload.
module up_counter_ctrl #(
  parameter int WIDTH  = 4,
  parameter int RUNS_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              pause,
  input  logic              abort,
  input  logic              mode,
  input  logic [WIDTH-1:0]  limit,
  input  logic [WIDTH-1:0]  cnt_val,
  output logic              cnt_en,
  output logic              cnt_clr,
  output logic              busy,
  output logic              done,
  output logic [RUNS_W-1:0] runs
);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    HOLD,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] lim_q;
  logic             mode_q;
  logic             terminal;

  assign terminal = (cnt_val == lim_q);

  // Outputs decode straight from state so reset silences them without a clock edge.
  // HOLD with pause released counts in the same cycle, so a pause costs only its own length.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    cnt_en  = 1'b0;
    cnt_clr = 1'b0;
    busy    = (state != IDLE);
    done    = (state == DONE);
    if ((state == RUN || state == HOLD) && !pause && !abort && !terminal)
      cnt_en = 1'b1;
    if (state == CLEAR || (abort && state != IDLE))
      cnt_clr = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      lim_q  <= '0;
      mode_q <= 1'b0;
      runs   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            lim_q  <= limit;
            mode_q <= mode;
            runs   <= '0;
            state  <= CLEAR;
          end
        end
        CLEAR: begin
          state <= abort ? IDLE : RUN;
        end
        RUN: begin
          if (abort) begin
            state <= IDLE;
          end else if (terminal) begin
            if (runs != '1)
              runs <= runs + 1'b1;
            state <= mode_q ? CLEAR : DONE;
          end else if (pause) begin
            state <= HOLD;
          end
        end
        HOLD: begin
          if (abort)
            state <= IDLE;
          else if (!pause)
            state <= RUN;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
